// File: rtl/cache_line_fill_responder_if.sv
// ---------------------------------------------------------------------------
// cache_line_fill_responder_if
//
// Bundles the signals of the cache line-fill responder. It carries both the
// cache-facing handshake and the SDRAM controller read port.
//
// Cache side:
//   req, req_addr, inval   cache -> responder
//   fill, fill_data, busy  responder -> cache
// SDRAM side:
//   mem_req, mem_addr              responder -> controller
//   mem_ack, mem_rvalid, mem_rdata controller -> responder
//
// Modports:
//   slave  - the responder's view
//   master - the environment's view (cache plus controller)
// ---------------------------------------------------------------------------
interface cache_line_fill_responder_if #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 16
);
   logic              req;
   logic [ADDR_W-1:0] req_addr;
   logic              inval;
   logic              fill;
   logic [DATA_W-1:0] fill_data;
   logic              busy;
   logic              mem_req;
   logic [ADDR_W-4:0] mem_addr;
   logic              mem_ack;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req, req_addr, inval, mem_ack, mem_rvalid, mem_rdata,
      output fill, fill_data, busy, mem_req, mem_addr
   );

   modport master (
      output req, req_addr, inval, mem_ack, mem_rvalid, mem_rdata,
      input  fill, fill_data, busy, mem_req, mem_addr
   );
endinterface

// File: rtl/cache_line_fill_responder.sv
// ---------------------------------------------------------------------------
// cache_line_fill_responder
//
// Memory-side responder for the two-way cache's line fill. A fill request
// triggers one 4-word line read from the SDRAM controller. The returned words
// are buffered and then streamed back critical-word-first on four
// consecutive cycles. Every output is a register or a decode of registered
// state.
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      cache_line_fill_responder_if.slave:
//              req/req_addr/inval in; fill/fill_data/busy out;
//              mem_req/mem_addr out; mem_ack/mem_rvalid/mem_rdata in
//
// Optional feature (macro LINEBUF_EN):
//   Keeps the tag of the last streamed line plus a valid bit. A request that
//   hits that line streams straight from the buffer without an SDRAM read.
//   inval clears the valid bit. When LINEBUF_EN is undefined, inval is
//   ignored and no tag logic exists.
// ---------------------------------------------------------------------------
module cache_line_fill_responder #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   cache_line_fill_responder_if.slave       bus
);
   localparam int LINE_W = ADDR_W - 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_COLLECT,
      S_STREAM,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [1:0]          crit_q, crit_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                fill_q, fill_d;
   logic [DATA_W-1:0]   fill_data_q, fill_data_d;
   logic [DATA_W-1:0]   line_buf_q [4];
   logic [1:0]          rd_idx;
   logic                hit;
   logic                last_word;
   logic                stream_done;
   logic                unused_addr0;

   // Only word addresses matter; the byte-select bit is never used.
   assign unused_addr0 = bus.req_addr[0];

   // Stream index wraps at 4 words, so the critical word comes first.
   assign rd_idx      = crit_q + cnt_q;
   assign last_word   = (state_q == S_COLLECT) && bus.mem_rvalid && (cnt_q == 2'd3);
   assign stream_done = (state_q == S_STREAM) && (cnt_q == 2'd3);

`ifdef LINEBUF_EN
   logic [LINE_W-1:0] tag_q, tag_d;
   logic              valid_q, valid_d;
   logic              stale_q, stale_d;

   // An inval in the same cycle as the request wins over the hit.
   assign hit = valid_q && !bus.inval && (tag_q == bus.req_addr[ADDR_W-1:3]);

   always_comb begin
      valid_d = valid_q;
      stale_d = stale_q;
      tag_d   = tag_q;
      if ((state_q == S_IDLE) && bus.req) begin
         stale_d = 1'b0;
         // A miss overwrites the buffer, so the old tag no longer applies.
         if (!hit) valid_d = 1'b0;
      end
      // An invalidate that arrives while the line is in flight must stop
      // this line from being marked valid when the stream completes.
      if (bus.inval && ((state_q == S_COLLECT) || (state_q == S_STREAM)))
         stale_d = 1'b1;
      if (stream_done) begin
         tag_d   = line_q;
         valid_d = !stale_q && !bus.inval;
      end
      if (bus.inval) valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         stale_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         stale_q <= stale_d;
      end
      tag_q <= tag_d;
   end
`else
   logic unused_inval;

   assign hit          = 1'b0;
   assign unused_inval = bus.inval;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.req)     state_d = hit ? S_STREAM : S_ISSUE;
         S_ISSUE:   if (bus.mem_ack) state_d = S_COLLECT;
         S_COLLECT: if (last_word)   state_d = S_STREAM;
         S_STREAM:  if (stream_done) state_d = S_DONE;
         S_DONE:    if (!bus.req)    state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // Output and datapath next-state logic
   always_comb begin
      line_d      = line_q;
      crit_d      = crit_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      fill_d      = 1'b0;
      fill_data_d = fill_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               line_d    = bus.req_addr[ADDR_W-1:3];
               crit_d    = bus.req_addr[2:1];
               cnt_d     = 2'd0;
               mem_req_d = !hit;
            end
         end
         S_ISSUE: begin
            if (bus.mem_ack) mem_req_d = 1'b0;
         end
         S_COLLECT: begin
            if (bus.mem_rvalid) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  // Word 0 of the stream leaves on the cycle after the last
                  // rvalid. If the critical word is the one arriving now,
                  // it bypasses the buffer. The stream then resumes at i=1.
                  fill_d      = 1'b1;
                  fill_data_d = (crit_q == 2'd3) ? bus.mem_rdata : line_buf_q[crit_q];
                  cnt_d       = 2'd1;
               end
            end
         end
         S_STREAM: begin
            fill_d      = (cnt_q == 2'd0);
            fill_data_d = line_buf_q[rd_idx];
            cnt_d       = cnt_q + 2'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q       <= 2'd0;
         mem_req_q   <= 1'b0;
         fill_q      <= 1'b0;
         fill_data_q <= '0;
         line_q      <= '0;
      end else begin
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         fill_q      <= fill_d;
         fill_data_q <= fill_data_d;
         line_q      <= line_d;
      end
      crit_q <= crit_d;
   end

   always_ff @(posedge clk) begin
      if ((state_q == S_COLLECT) && bus.mem_rvalid)
         line_buf_q[cnt_q] <= bus.mem_rdata;
   end

   assign bus.fill      = fill_q;
   assign bus.fill_data = fill_data_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = line_q;
endmodule

// File: tb/tb_cache_line_fill_responder.sv
module tb_cache_line_fill_responder;
   localparam int ADDR_W = 26;
   localparam int DATA_W = 16;

   logic clk;
   logic reset_n;
   int   n_total;
   int   n_bad;

   cache_line_fill_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   cache_line_fill_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise req and check that the SDRAM request comes up on the next cycle.
   task automatic issue_req(input logic [ADDR_W-1:0] addr, input logic [31:0] exp_line);
      bus_if.req      = 1'b1;
      bus_if.req_addr = addr;
      tick();
      chk("mem_req_up", bus_if.mem_req, 1);
      chk("mem_addr", bus_if.mem_addr, exp_line);
      chk("busy_up", bus_if.busy, 1);
   endtask

   task automatic do_ack(input int delay);
      for (int d = 0; d < delay; d++) begin
         tick();
         chk("mem_req_hold", bus_if.mem_req, 1);
      end
      bus_if.mem_ack = 1'b1;
      tick();
      bus_if.mem_ack = 1'b0;
      chk("mem_req_drop", bus_if.mem_req, 0);
   endtask

   task automatic send_words(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                             input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                             input int gap);
      logic [DATA_W-1:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < 4; i++) begin
         bus_if.mem_rvalid = 1'b1;
         bus_if.mem_rdata  = w[i];
         tick();
         bus_if.mem_rvalid = 1'b0;
         bus_if.mem_rdata  = 16'hDEAD;
         if (i < 3) begin
            chk("no_early_fill", bus_if.fill, 0);
            for (int g = 0; g < gap; g++) begin
               tick();
               chk("gap_no_fill", bus_if.fill, 0);
            end
         end
      end
   endtask

   // Called on the cycle where fill must be high.
   task automatic check_stream(input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                               input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3,
                               input bit hold);
      logic [DATA_W-1:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      chk("fill_first", bus_if.fill, 1);
      chk("data_0", bus_if.fill_data, e[0]);
      if (!hold) bus_if.req = 1'b0;
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("fill_low", bus_if.fill, 0);
         chk("data_n", bus_if.fill_data, e[i]);
      end
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_busy", bus_if.busy, 1);
            chk("held_no_mem_req", bus_if.mem_req, 0);
            chk("held_no_fill", bus_if.fill, 0);
         end
         bus_if.req = 1'b0;
      end
      tick();
      chk("back_idle", bus_if.busy, 0);
      chk("data_hold", bus_if.fill_data, e[3]);
      chk("idle_fill", bus_if.fill, 0);
   endtask

   initial begin
      n_total           = 0;
      n_bad             = 0;
      reset_n           = 1'b0;
      bus_if.req        = 1'b0;
      bus_if.req_addr   = '0;
      bus_if.inval      = 1'b0;
      bus_if.mem_ack    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = '0;
      tick();
      tick();
      chk("rst_fill", bus_if.fill, 0);
      chk("rst_data", bus_if.fill_data, 0);
      chk("rst_mem_req", bus_if.mem_req, 0);
      chk("rst_busy", bus_if.busy, 0);
      reset_n = 1'b1;
      tick();

      // Basic fill, crit word 0, ack after 2 cycles
      issue_req(26'h000010, 32'h2);
      do_ack(2);
      send_words(16'hA000, 16'hA001, 16'hA002, 16'hA003, 0);
      check_stream(16'hA000, 16'hA001, 16'hA002, 16'hA003, 1'b0);

      // Critical-word wrap (same line, so drop any buffered copy first)
      bus_if.inval = 1'b1;
      tick();
      bus_if.inval = 1'b0;
      issue_req(26'h000016, 32'h2);
      do_ack(0);
      send_words(16'hB000, 16'hB001, 16'hB002, 16'hB003, 0);
      check_stream(16'hB003, 16'hB000, 16'hB001, 16'hB002, 1'b0);

      // Gapped rvalid, crit=2, req held after fill
      issue_req(26'h000024, 32'h4);
      do_ack(1);
      send_words(16'hE000, 16'hE001, 16'hE002, 16'hE003, 3);
      check_stream(16'hE002, 16'hE003, 16'hE000, 16'hE001, 1'b1);

      // Reset in the middle of COLLECT
      issue_req(26'h000040, 32'h8);
      do_ack(1);
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 16'h1111;
      tick();
      bus_if.mem_rdata  = 16'h2222;
      tick();
      bus_if.mem_rvalid = 1'b0;
      bus_if.req        = 1'b0;
      reset_n           = 1'b0;
      tick();
      chk("mid_rst_fill", bus_if.fill, 0);
      chk("mid_rst_data", bus_if.fill_data, 0);
      chk("mid_rst_mem_req", bus_if.mem_req, 0);
      chk("mid_rst_busy", bus_if.busy, 0);
      chk("mid_rst_addr", bus_if.mem_addr, 0);
      reset_n = 1'b1;
      tick();
      issue_req(26'h000040, 32'h8);
      do_ack(0);
      send_words(16'hD000, 16'hD001, 16'hD002, 16'hD003, 0);
      check_stream(16'hD000, 16'hD001, 16'hD002, 16'hD003, 1'b0);

      // Repeat request to one line (crit=1)
      issue_req(26'h000030, 32'h6);
      do_ack(0);
      send_words(16'hC000, 16'hC001, 16'hC002, 16'hC003, 0);
      check_stream(16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b0);
`ifdef LINEBUF_EN
      bus_if.req      = 1'b1;
      bus_if.req_addr = 26'h000032;
      tick();
      chk("hit_no_mem_req", bus_if.mem_req, 0);
      chk("hit_no_fill_yet", bus_if.fill, 0);
      chk("hit_busy", bus_if.busy, 1);
      tick();
      check_stream(16'hC001, 16'hC002, 16'hC003, 16'hC000, 1'b0);
      bus_if.inval = 1'b1;
      tick();
      bus_if.inval = 1'b0;
`endif
      issue_req(26'h000032, 32'h6);
      do_ack(0);
      send_words(16'hC100, 16'hC101, 16'hC102, 16'hC103, 0);
      check_stream(16'hC101, 16'hC102, 16'hC103, 16'hC100, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
